// File: rtl/gen_stream_reducer.sv
// Stream reducer: collects an upstream valid/done stream into sum, count, max and
// overflow, then presents the result as one beat under the __valid/__ready/__done protocol.
module gen_stream_reducer #(
   parameter int WIDTH     = 32,
   parameter int CNT_WIDTH = 32
) (
   input  logic                 __clock,
   input  logic                 __reset,
   input  logic                 __start,
   input  logic                 in_valid,
   input  logic [WIDTH-1:0]     in_data,
   input  logic                 in_done,
   output logic                 in_ready,
   input  logic                 __ready,
   output logic                 __valid,
   output logic                 __done,
   output logic [WIDTH-1:0]     __output_0,
   output logic [CNT_WIDTH-1:0] __output_1,
   output logic [WIDTH-1:0]     __output_2,
   output logic                 __output_3
);

   typedef enum logic [1:0] {
      ST_START   = 2'd0,
      ST_COLLECT = 2'd1,
      ST_EMIT    = 2'd2
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

   state_t               r_state;
   logic [WIDTH-1:0]     r_sum;
   logic [WIDTH-1:0]     r_max;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic                 r_ovf;

   logic                 w_accept;
   logic [WIDTH:0]       w_add;
   logic [WIDTH-1:0]     w_sum_nx;
   logic [WIDTH-1:0]     w_max_nx;
   logic [CNT_WIDTH-1:0] w_cnt_nx;
   logic                 w_ovf_nx;

   // Held high through all of COLLECT so a registered upstream valid never stalls.
   assign in_ready = (r_state == ST_COLLECT);
   assign w_accept = in_valid && in_ready;
   assign w_add    = {1'b0, r_sum} + {1'b0, in_data};

   // Next accumulator values; also used as the same-edge bypass when in_done arrives.
   always_comb begin
      w_sum_nx = r_sum;
      w_max_nx = r_max;
      w_cnt_nx = r_cnt;
      w_ovf_nx = r_ovf;
      if (w_accept) begin
         w_sum_nx = w_add[WIDTH-1:0];
         w_ovf_nx = r_ovf | w_add[WIDTH];
         w_cnt_nx = (r_cnt == CNT_MAX) ? r_cnt : (r_cnt + CNT_ONE);
         w_max_nx = (in_data > r_max) ? in_data : r_max;
      end else begin
         w_sum_nx = r_sum;
      end
   end

   // Session FSM with accumulators and registered result beat.
   always_ff @(posedge __clock or posedge __reset) begin
      if (__reset) begin
         r_state    <= ST_START;
         r_sum      <= '0;
         r_max      <= '0;
         r_cnt      <= '0;
         r_ovf      <= 1'b0;
         __valid    <= 1'b0;
         __done     <= 1'b0;
         __output_0 <= '0;
         __output_1 <= '0;
         __output_2 <= '0;
         __output_3 <= 1'b0;
      end else begin
         __done <= 1'b0;
         case (r_state)
            ST_START: begin
               r_sum <= '0;
               r_max <= '0;
               r_cnt <= '0;
               r_ovf <= 1'b0;
               if (__start) begin
                  r_state <= ST_COLLECT;
               end else begin
                  r_state <= ST_START;
               end
            end
            ST_COLLECT: begin
               r_sum <= w_sum_nx;
               r_max <= w_max_nx;
               r_cnt <= w_cnt_nx;
               r_ovf <= w_ovf_nx;
               if (in_done) begin
                  __output_0 <= w_sum_nx;
                  __output_1 <= w_cnt_nx;
                  __output_2 <= w_max_nx;
                  __output_3 <= w_ovf_nx;
                  __valid    <= 1'b1;
                  r_state    <= ST_EMIT;
               end else begin
                  r_state <= ST_COLLECT;
               end
            end
            ST_EMIT: begin
               if (__valid && __ready) begin
                  __valid <= 1'b0;
                  __done  <= 1'b1;
                  r_state <= ST_START;
               end else begin
                  r_state <= ST_EMIT;
               end
            end
            default: begin
               __valid <= 1'b0;
               r_state <= ST_START;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gen_stream_reducer.sv
// Self-checking bench for gen_stream_reducer (WIDTH=8, CNT_WIDTH=4): table-driven
// sessions with a result scoreboard, plus hand-written reset and empty-stream sequences.
module tb_gen_stream_reducer;

   localparam int W = 8;
   localparam int C = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         in_valid;
   logic [W-1:0] in_data;
   logic         in_done;
   logic         in_ready;
   logic         rdy;
   logic         dut_valid;
   logic         dut_done;
   logic [W-1:0] o_sum;
   logic [C-1:0] o_cnt;
   logic [W-1:0] o_max;
   logic         o_ovf;

   typedef struct packed {
      logic [W-1:0] sum;
      logic [C-1:0] cnt;
      logic [W-1:0] max;
      logic         ovf;
   } res_t;

   typedef struct {
      string              name;
      int                 n;
      logic [19:0][W-1:0] beats;     // beats[0] is sent first
      bit                 same_edge; // last beat accepted on the in_done edge
      int                 pre_idle;
      int                 rdy_dly;
      res_t               exp;
   } vec_t;

   vec_t vecs [6];
   res_t exp_q [$];
   int   n_chk  = 0;
   int   n_fail = 0;
   bit   done_due = 1'b0;

   always #5 clk = ~clk;

   gen_stream_reducer #(.WIDTH(W), .CNT_WIDTH(C)) dut (
      .__clock    (clk),
      .__reset    (rst),
      .__start    (start),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_done    (in_done),
      .in_ready   (in_ready),
      .__ready    (rdy),
      .__valid    (dut_valid),
      .__done     (dut_done),
      .__output_0 (o_sum),
      .__output_1 (o_cnt),
      .__output_2 (o_max),
      .__output_3 (o_ovf)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_res(input string name, input res_t exp);
      check({name, " sum"}, 32'(o_sum), 32'(exp.sum));
      check({name, " cnt"}, 32'(o_cnt), 32'(exp.cnt));
      check({name, " max"}, 32'(o_max), 32'(exp.max));
      check({name, " ovf"}, 32'(o_ovf), 32'(exp.ovf));
   endtask

   // Scoreboard: pop on each observed transfer, and police the __done pulse.
   always @(negedge clk) begin
      if (done_due) begin
         check("done after transfer", 32'(dut_done), 32'd1);
         done_due = 1'b0;
      end else if (dut_done === 1'b1) begin
         check("unexpected done", 32'(dut_done), 32'd0);
      end
      if (dut_valid === 1'b1 && rdy === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("transfer with empty scoreboard", 32'd1, 32'd0);
         end else begin
            check_res("transfer", exp_q.pop_front());
         end
         done_due = 1'b1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input string name);
      int k;
      for (k = 0; k < 20; k++) begin
         tick();
         if (dut_done === 1'b1) break;
      end
      if (k == 20) check({name, " done timeout"}, 32'd0, 32'd1);
   endtask

   task automatic run_vec(input vec_t v);
      rdy   = (v.rdy_dly == 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      check({v.name, " in_ready collect"}, 32'(in_ready), 32'd1);
      for (int i = 0; i < v.pre_idle; i++) tick();
      for (int i = 0; i < v.n; i++) begin
         in_valid = 1'b1;
         in_data  = v.beats[i];
         in_done  = v.same_edge && (i == v.n - 1);
         if (in_done) exp_q.push_back(v.exp);
         tick();
      end
      if (!v.same_edge || v.n == 0) begin
         in_valid = 1'b0;
         in_done  = 1'b1;
         exp_q.push_back(v.exp);
         tick();
      end
      in_valid = 1'b0;
      in_done  = 1'b0;
      check({v.name, " valid latency"}, 32'(dut_valid), 32'd1);
      for (int k = 0; k < v.rdy_dly; k++) begin
         check({v.name, " bp valid"}, 32'(dut_valid), 32'd1);
         check({v.name, " bp in_ready"}, 32'(in_ready), 32'd0);
         check_res({v.name, " bp hold"}, v.exp);
         in_valid = 1'b1;
         in_data  = 8'hFF;
         in_done  = 1'b1;
         start    = 1'b1;
         tick();
         in_valid = 1'b0;
         in_done  = 1'b0;
         start    = 1'b0;
      end
      rdy = 1'b1;
      wait_done(v.name);
      check({v.name, " valid dropped"}, 32'(dut_valid), 32'd0);
      tick();
      check_res({v.name, " hold between sessions"}, v.exp);
   endtask

   initial begin
      vecs[0] = '{name: "fib", n: 7, same_edge: 1'b0, pre_idle: 0, rdy_dly: 0,
                  beats: 160'({8'd55, 8'd21, 8'd13, 8'd5, 8'd3, 8'd1, 8'd1}),
                  exp: '{sum: 8'd99, cnt: 4'd7, max: 8'd55, ovf: 1'b0}};
      vecs[1] = '{name: "same-edge zero", n: 3, same_edge: 1'b1, pre_idle: 0, rdy_dly: 0,
                  beats: 160'({8'd0, 8'd8, 8'd2}),
                  exp: '{sum: 8'd10, cnt: 4'd3, max: 8'd8, ovf: 1'b0}};
      vecs[2] = '{name: "backpressure", n: 2, same_edge: 1'b0, pre_idle: 0, rdy_dly: 5,
                  beats: 160'({8'd9, 8'd4}),
                  exp: '{sum: 8'd13, cnt: 4'd2, max: 8'd9, ovf: 1'b0}};
      vecs[3] = '{name: "overflow", n: 2, same_edge: 1'b0, pre_idle: 0, rdy_dly: 0,
                  beats: 160'({8'd100, 8'd200}),
                  exp: '{sum: 8'd44, cnt: 4'd2, max: 8'd200, ovf: 1'b1}};
      vecs[4] = '{name: "count saturate", n: 17, same_edge: 1'b0, pre_idle: 0, rdy_dly: 0,
                  beats: {20{8'd1}},
                  exp: '{sum: 8'd17, cnt: 4'd15, max: 8'd1, ovf: 1'b0}};
      vecs[5] = '{name: "empty", n: 0, same_edge: 1'b0, pre_idle: 1, rdy_dly: 0,
                  beats: '0,
                  exp: '{sum: 8'd0, cnt: 4'd0, max: 8'd0, ovf: 1'b0}};

      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; in_done = 1'b0; rdy = 1'b1;
      tick();
      tick();
      check("reset valid", 32'(dut_valid), 32'd0);
      check("reset done", 32'(dut_done), 32'd0);
      check("reset in_ready", 32'(in_ready), 32'd0);
      check_res("reset", '{sum: 8'd0, cnt: 4'd0, max: 8'd0, ovf: 1'b0});
      rst = 1'b0;
      tick();
      check("idle in_ready", 32'(in_ready), 32'd0);

      foreach (vecs[i]) run_vec(vecs[i]);

      // Async reset mid-COLLECT: the session is abandoned with no beat and no done.
      start = 1'b1;
      tick();
      start = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'd7;
      tick();
      tick();
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("async reset valid", 32'(dut_valid), 32'd0);
      check("async reset in_ready", 32'(in_ready), 32'd0);
      check_res("async reset", '{sum: 8'd0, cnt: 4'd0, max: 8'd0, ovf: 1'b0});
      tick();
      rst = 1'b0;
      tick();
      tick();
      check("post reset no valid", 32'(dut_valid), 32'd0);
      run_vec('{name: "after reset", n: 1, same_edge: 1'b0, pre_idle: 0, rdy_dly: 0,
                beats: 160'(8'd3),
                exp: '{sum: 8'd3, cnt: 4'd1, max: 8'd3, ovf: 1'b0}});

      check("scoreboard drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/gen_stream_reducer.md
Name: gen_stream_reducer

Overview:
- Consumer stage placed directly downstream of a generated generator module (for example, the even-Fibonacci generator).
- Accepts that module's output stream (valid/ready data beats, terminated by a one-cycle done pulse) and reduces it to sum, beat count, unsigned maximum and an overflow flag.
- Presents the result as one output beat under the standard __valid/__ready/__done generator protocol, so it can chain into further generated stages.

Parameters:
WIDTH, 32, width of in_data and of the sum and max results
CNT_WIDTH, 32, width of the beat counter

Ports:
__clock  input  1  clock; all logic on rising edge
__reset  input  1  reset, asynchronous, active-high
__start  input  1  begins a collection session; sampled only in START
in_valid  input  1  upstream beat valid (the upstream stage's __valid)
in_data  input  WIDTH  upstream beat data (the upstream stage's __output_0)
in_done  input  1  upstream end-of-stream pulse (the upstream stage's __done)
in_ready  output  1  drives the upstream stage's __ready
__ready  input  1  downstream accepts the result beat
__valid  output  1  result beat valid
__done  output  1  one-cycle pulse after the result has transferred
__output_0  output  WIDTH  sum of accepted beats, mod 2^WIDTH
__output_1  output  CNT_WIDTH  count of accepted beats, saturating at all-ones
__output_2  output  WIDTH  unsigned maximum of accepted beats (0 if no beats)
__output_3  output  1  sticky: sum wrapped at least once this session

Behaviour:
- Reset is asynchronous on __reset high. It forces:
  - state = START
  - __valid, __done, __output_0..3 = 0
  - sum, count, max and overflow accumulators = 0
- Reset asserted mid-session abandons the session. No result beat and no __done are produced for it.
- in_ready is combinational and equals (state == COLLECT). It is 1 for the whole of COLLECT, even while in_valid is low, so the upstream registered valid never stalls.
- __done is registered. It defaults to 0 every cycle and is high for exactly one cycle per completed session.
- State START:
  - Accumulators are cleared every cycle.
  - If __start = 1, go to COLLECT on the next edge. Otherwise stay in START.
- State COLLECT, accept event (in_valid && in_ready at the edge):
  - sum += in_data, modulo 2^WIDTH.
  - overflow |= carry-out of that add.
  - count += 1, holding at all-ones once reached.
  - max = in_data if in_data > max (unsigned compare).
  - Zero-valued beats are ordinary beats and are counted.
- State COLLECT, end of stream:
  - in_done = 1 at an edge loads __output_0..3 with the final values and sets __valid = 1. Next state is EMIT.
  - If a beat is accepted in that same edge, it is included in the loaded values (same-edge bypass of the accumulator update).
- State EMIT:
  - in_ready = 0; upstream activity and in_done are ignored.
  - Outputs hold stable while __valid = 1 and __ready = 0.
  - On the edge where __valid && __ready: __valid <= 0, __done <= 1, state <= START.
  - Latency: the result beat is presented 1 cycle after in_done and transfers on the first edge with __ready high. __done is high for the cycle following the transfer.
- __start outside START is ignored. __start held high in START immediately begins a new session.
- An empty stream (in_done with no accepted beats) yields sum 0, count 0, max 0, overflow 0.
- __output_0..3 keep their last value between sessions. They are only updated on the COLLECT-to-EMIT transition.

Test Plan:
- Basic odd-Fibonacci stream: __start pulse, then beats 1,1,3,5,13,21,55 with in_done in the cycle after the last beat, __ready = 1 → one __valid beat with __output_0 = 99, __output_1 = 7, __output_2 = 55, __output_3 = 0; __done high exactly one cycle after the transfer.
- Trailing-zero and same-edge done: beats 2,8,0, where the beat 0 is accepted in the same edge as in_done → sum 10, count 3, max 8.
- Empty stream: __start, then in_done two cycles later with no beats → result 0,0,0,0 presented one cycle after in_done.
- Backpressure: stream 4,9 with __ready held low 5 cycles after __valid rises → __valid and outputs (13,2,9,0) stable for all 5 cycles, in_ready = 0 throughout; __done pulses once after __ready rises.
- Overflow, WIDTH = 8: beats 200,100 → __output_0 = 44, __output_3 = 1, __output_2 = 200, __output_1 = 2.
- Reset mid-COLLECT: async __reset high between edges after beats 7,7 → outputs 0 immediately and no __done. A new session with beat 3 then yields 3,1,3,0.
